// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the core-to-memory/GPIO bus arbiter.
//   ADDR_W      : shared bus address width (top bit selects GPIO space)
//   DATA_W      : shared bus data width
//   GPIO_BIT    : address bit that selects GPIO instead of RAM
//   arb_state_t : arbiter FSM states
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 8;
  localparam int GPIO_BIT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  // True when an address targets the GPIO window rather than RAM.
  function automatic logic addr_is_gpio(input logic [ADDR_W-1:0] addr);
    return addr[GPIO_BIT];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. The search starts at i_rr_ptr
// and ascends modulo N_CORES; the first requesting core found wins.
// Ports:
//   i_req    [N_CORES-1:0] : request vector
//   i_rr_ptr [IDX_W-1:0]   : index that has highest priority this round
//   o_valid                : at least one request is present
//   o_win    [IDX_W-1:0]   : index of the winning core (0 when !o_valid)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_CORES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [N_CORES-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_win
);

  int w_idx;

  // Scan from the farthest candidate down to rr_ptr itself so that the
  // closest requester (in ascending order from rr_ptr) is assigned last.
  always_comb begin
    o_valid = 1'b0;
    o_win   = '0;
    w_idx   = 0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      w_idx = (int'(i_rr_ptr) + k) % N_CORES;
      if ((i_req & (N_CORES'(1'b1) << w_idx)) != '0) begin
        o_valid = 1'b1;
        o_win   = IDX_W'(w_idx);
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter sharing one memory/GPIO bus among N_CORES cores. One
// request is serviced at a time: IDLE -> ACCESS -> WAIT (MEM_LATENCY cycles)
// -> RESPOND, where a single-cycle one-hot grant is issued with read data.
// All outputs are registered.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_req             : per-core request
//   i_req_rw          : per-core direction, 1 = write, 0 = read
//   i_req_addr        : per-core 9-bit address, core i at [9i+8:9i]
//   i_req_wdata       : per-core write data, core i at [8i+7:8i]
//   o_grant           : per-core one-hot completion pulse
//   o_rdata           : read data, valid while o_grant is nonzero
//   o_bus_addr        : shared bus address (bit 8 = GPIO space)
//   o_bus_we          : shared bus write strobe, high only in ACCESS
//   o_bus_wdata       : shared bus write data
//   i_bus_rdata       : shared bus read data
//   o_busy            : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_CORES     = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CORES-1:0]        i_req,
  input  logic [N_CORES-1:0]        i_req_rw,
  input  logic [ADDR_W*N_CORES-1:0] i_req_addr,
  input  logic [DATA_W*N_CORES-1:0] i_req_wdata,
  output logic [N_CORES-1:0]        o_grant,
  output logic [DATA_W-1:0]         o_rdata,
  output logic [ADDR_W-1:0]         o_bus_addr,
  output logic                      o_bus_we,
  output logic [DATA_W-1:0]         o_bus_wdata,
  input  logic [DATA_W-1:0]         i_bus_rdata,
  output logic                      o_busy
);

  localparam int IDX_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int WAIT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_LATENCY - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CORES - 1);

  arb_state_t        r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_win;
  logic              r_rw;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic              w_valid;
  logic [IDX_W-1:0]  w_win;
  logic              w_sel_rw;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [IDX_W-1:0]  w_next_ptr;

  rr_pick #(
    .N_CORES (N_CORES),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_valid),
    .o_win    (w_win)
  );

  // Select the winning core's transfer fields out of the packed request buses.
  always_comb begin
    w_sel_rw    = 1'((i_req_rw >> w_win));
    w_sel_addr  = ADDR_W'((i_req_addr >> (ADDR_W * int'(w_win))));
    w_sel_wdata = DATA_W'((i_req_wdata >> (DATA_W * int'(w_win))));
    if (r_win == LAST_IDX) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = r_win + IDX_W'(1);
    end
  end

  // Arbiter FSM with transfer latches, wait counter and registered outputs.
  // o_bus_addr/o_bus_wdata double as the address/data latches and are held
  // until the next transfer is won.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_win       <= '0;
      r_rw        <= 1'b0;
      r_wait_cnt  <= '0;
      o_grant     <= '0;
      o_rdata     <= '0;
      o_bus_addr  <= '0;
      o_bus_we    <= 1'b0;
      o_bus_wdata <= '0;
      o_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_grant <= '0;
          if (w_valid) begin
            r_win       <= w_win;
            r_rw        <= w_sel_rw;
            o_bus_addr  <= w_sel_addr;
            o_bus_wdata <= w_sel_wdata;
            o_bus_we    <= w_sel_rw;
            o_busy      <= 1'b1;
            r_state     <= ACCESS;
          end else begin
            o_bus_we <= 1'b0;
            o_busy   <= 1'b0;
          end
        end
        ACCESS: begin
          o_bus_we   <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (r_wait_cnt == LAST_WAIT) begin
            // Writes leave the previous read data untouched.
            if (!r_rw) begin
              o_rdata <= i_bus_rdata;
            end else begin
              o_rdata <= o_rdata;
            end
            o_grant <= N_CORES'(1'b1) << r_win;
            r_state <= RESPOND;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        RESPOND: begin
          o_grant  <= '0;
          r_rr_ptr <= w_next_ptr;
          o_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          o_grant  <= '0;
          o_bus_we <= 1'b0;
          o_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule
